// File: rtl/reg_write_scoreboard.sv
// reg_write_scoreboard: per-register pending-write / pending-load counters answering ID-stage hazard queries.
// Define SCOREBOARD_ERR_CHK_EN to add the sticky protocol-error output err_sticky.
module reg_write_scoreboard #(
   parameter int NUM_REGS = 16,
   parameter int CNT_W    = 2,
   localparam int IW      = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          forwarding_mode,
   input  logic [IW-1:0] src_1,
   input  logic [IW-1:0] src_2,
   input  logic          two_src,
   input  logic          issue_valid,
   input  logic          issue_wb_en,
   input  logic [IW-1:0] issue_dest,
   input  logic          issue_mem_read,
   output logic          issue_ready,
   input  logic          ldret_valid,
   input  logic [IW-1:0] ldret_dest,
   input  logic          retire_valid,
   input  logic [IW-1:0] retire_dest,
   output logic          busy_1,
   output logic          busy_2,
   output logic          hazard_detected
`ifdef SCOREBOARD_ERR_CHK_EN
   ,
   output logic          err_sticky
`endif
);
   localparam logic [CNT_W-1:0] MAX = '1;
   logic [CNT_W-1:0] pend_cnt [NUM_REGS];
   logic [CNT_W-1:0] load_cnt [NUM_REGS];
   logic [CNT_W-1:0] pend_nxt [NUM_REGS];
   logic [CNT_W-1:0] load_nxt [NUM_REGS];
   logic ret_hit, ld_hit, pend_ok, load_ok, accept;
   assign ret_hit = retire_valid && retire_dest == issue_dest;
   assign ld_hit  = ldret_valid && ldret_dest == issue_dest;
   assign pend_ok = pend_cnt[issue_dest] != MAX || ret_hit;
   // a same-cycle retire that would push load_cnt above pend_cnt also frees a load slot
   assign load_ok = !issue_mem_read || load_cnt[issue_dest] != MAX || ld_hit ||
                    (ret_hit && load_cnt[issue_dest] == pend_cnt[issue_dest]);
   assign issue_ready = !issue_wb_en || (pend_ok && load_ok);
   assign accept      = issue_valid && issue_wb_en && issue_ready;
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_next
      logic p_inc, l_inc, p_dec, l_dec;
      logic [CNT_W:0] p_sum, l_sum;
      assign p_inc = accept && issue_dest == IW'(r);
      assign l_inc = p_inc && issue_mem_read;
      assign p_dec = retire_valid && retire_dest == IW'(r) && pend_cnt[r] != '0;
      assign l_dec = ldret_valid && ldret_dest == IW'(r) && load_cnt[r] != '0;
      assign p_sum = {1'b0, pend_cnt[r]} + {{CNT_W{1'b0}}, p_inc} - {{CNT_W{1'b0}}, p_dec};
      assign l_sum = {1'b0, load_cnt[r]} + {{CNT_W{1'b0}}, l_inc} - {{CNT_W{1'b0}}, l_dec};
      assign pend_nxt[r] = p_sum[CNT_W-1:0];
      // loads are a subset of pending writes, so clamp to keep load_cnt <= pend_cnt
      assign load_nxt[r] = l_sum > p_sum ? p_sum[CNT_W-1:0] : l_sum[CNT_W-1:0];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            pend_cnt[i] <= '0;
            load_cnt[i] <= '0;
         end
      end else begin
         pend_cnt <= pend_nxt;
         load_cnt <= load_nxt;
      end
   assign busy_1 = (forwarding_mode ? load_cnt[src_1] : pend_cnt[src_1]) != '0;
   assign busy_2 = two_src && (forwarding_mode ? load_cnt[src_2] : pend_cnt[src_2]) != '0;
   assign hazard_detected = busy_1 || busy_2;
`ifdef SCOREBOARD_ERR_CHK_EN
   always_ff @(posedge clk or posedge rst)
      if (rst)
         err_sticky <= 1'b0;
      else if ((retire_valid && pend_cnt[retire_dest] == '0) ||
               (ldret_valid && load_cnt[ldret_dest] == '0) ||
               (issue_valid && issue_wb_en && !issue_ready))
         err_sticky <= 1'b1;
`endif
endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb_reg_write_scoreboard: directed and random stimulus against a count-based model of the scoreboard.
module tb_reg_write_scoreboard;
   logic clk = 0, rst = 0;
   logic forwarding_mode = 0, two_src = 0;
   logic [3:0] src_1 = 0, src_2 = 0, issue_dest = 0, ldret_dest = 0, retire_dest = 0;
   logic issue_valid = 0, issue_wb_en = 0, issue_mem_read = 0, ldret_valid = 0, retire_valid = 0;
   logic issue_ready, busy_1, busy_2, hazard_detected;
`ifdef SCOREBOARD_ERR_CHK_EN
   logic err_sticky;
`endif
   int n_cmp = 0, n_bad = 0;
   int pend [16];
   int load [16];

   always #5 clk = ~clk;

   reg_write_scoreboard dut (
      .clk(clk), .rst(rst), .forwarding_mode(forwarding_mode),
      .src_1(src_1), .src_2(src_2), .two_src(two_src),
      .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
      .issue_mem_read(issue_mem_read), .issue_ready(issue_ready),
      .ldret_valid(ldret_valid), .ldret_dest(ldret_dest),
      .retire_valid(retire_valid), .retire_dest(retire_dest),
      .busy_1(busy_1), .busy_2(busy_2), .hazard_detected(hazard_detected)
`ifdef SCOREBOARD_ERR_CHK_EN
      , .err_sticky(err_sticky)
`endif
   );

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
      end
   endtask

   // an issue is refused only when it would push a register past 3 writes in flight
   function automatic logic m_ready();
      int after;
      after = pend[issue_dest] + 1 - ((retire_valid && retire_dest == issue_dest) ? 1 : 0);
      return !issue_wb_en || after <= 3;
   endfunction

   function automatic logic m_busy(input logic [3:0] s);
      return forwarding_mode ? load[s] != 0 : pend[s] != 0;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int np [16];
      int nl [16];
      if (rst) begin
         foreach (pend[r]) begin pend[r] = 0; load[r] = 0; end
      end else begin
         np = pend;
         nl = load;
         if (issue_valid && issue_wb_en && m_ready()) begin
            np[issue_dest]++;
            if (issue_mem_read) nl[issue_dest]++;
         end
         if (retire_valid && pend[retire_dest] > 0) np[retire_dest]--;
         if (ldret_valid && load[ldret_dest] > 0) nl[ldret_dest]--;
         foreach (nl[r]) if (nl[r] > np[r]) nl[r] = np[r];
         pend = np;
         load = nl;
      end
   end

   always @(negedge clk) begin
      chk("ready", issue_ready, m_ready());
      chk("busy_1", busy_1, m_busy(src_1));
      chk("busy_2", busy_2, two_src && m_busy(src_2));
      chk("hazard", hazard_detected, m_busy(src_1) || (two_src && m_busy(src_2)));
   end

   task automatic tick();
      @(posedge clk);
      #1;
      issue_valid = 0; issue_wb_en = 0; issue_mem_read = 0;
      ldret_valid = 0; retire_valid = 0; two_src = 0;
   endtask

   task automatic issue(input logic [3:0] d, input logic ld);
      issue_valid = 1; issue_wb_en = 1; issue_mem_read = ld; issue_dest = d;
   endtask

   task automatic retire(input logic [3:0] d);
      retire_valid = 1; retire_dest = d;
   endtask

   function automatic logic [3:0] pick();
      return ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
   endfunction

   initial begin
      #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst_ready", issue_ready, 1'b1);
      chk("rst_hazard", hazard_detected, 1'b0);
`ifdef SCOREBOARD_ERR_CHK_EN
      retire(4'd9);
      tick();
      chk("err_r9", err_sticky, 1'b1);
`endif
      // forwarding off: plain ALU write on R3
      issue(4'd3, 0);
      tick();
      src_1 = 3;
      #1 chk("add_hazard", hazard_detected, 1'b1);
      retire(4'd3);
      #1 chk("add_hazard_no_bypass", hazard_detected, 1'b1);
      tick();
      chk("ret_hazard", hazard_detected, 1'b0);
      // forwarding on: load to R5 blocks until its data leaves MEM
      forwarding_mode = 1;
      issue(4'd5, 1);
      tick();
      two_src = 1; src_2 = 5;
      #1 chk("ld_busy_2", busy_2, 1'b1);
      ldret_valid = 1; ldret_dest = 5;
      tick();
      two_src = 1;
      #1 chk("ldret_busy_2", busy_2, 1'b0);
      forwarding_mode = 0;
      #1 chk("ldret_pend_busy_2", busy_2, 1'b1);
      retire(4'd5);
      tick();
      // saturation on R7
      repeat (3) begin issue(4'd7, 0); tick(); end
      issue(4'd7, 0);
      #1 chk("sat_ready", issue_ready, 1'b0);
      retire(4'd7);
      #1 chk("sat_ready_ret", issue_ready, 1'b1);
      tick();
      src_1 = 7; issue_wb_en = 1; issue_dest = 7;
      #1 chk("sat_busy_1", busy_1, 1'b1);
      chk("sat_still_full", issue_ready, 1'b0);
      repeat (3) begin retire(4'd7); tick(); end
      chk("sat_drained", busy_1, 1'b0);
      // simultaneous issue and retire on R2 at count 1
      issue(4'd2, 0);
      tick();
      issue(4'd2, 0); retire(4'd2);
      tick();
      src_1 = 2;
      #1 chk("sim_busy", busy_1, 1'b1);
      retire(4'd2);
      tick();
      chk("sim_one_left", busy_1, 1'b0);
      // two_src gating on R4
      issue(4'd4, 0);
      tick();
      src_2 = 4;
      #1 chk("nosrc2_busy_2", busy_2, 1'b0);
      two_src = 1;
      #1 chk("src2_busy_2", busy_2, 1'b1);
      // reset mid-run with R4 pending
      src_1 = 4;
      rst = 1;
      #1 chk("midrst_busy_1", busy_1, 1'b0);
      chk("midrst_ready", issue_ready, 1'b1);
      tick();
      rst = 0;
      #1 chk("postrst_busy_1", busy_1, 1'b0);
      // random phase
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         rst = $urandom_range(0, 299) == 0;
         forwarding_mode = 1'($urandom_range(0, 1));
         src_1 = pick(); src_2 = pick(); two_src = 1'($urandom_range(0, 1));
         issue_valid = 1'($urandom_range(0, 1));
         issue_wb_en = $urandom_range(0, 3) != 0;
         issue_mem_read = 1'($urandom_range(0, 1));
         issue_dest = pick();
         ldret_valid = $urandom_range(0, 2) == 0; ldret_dest = pick();
         retire_valid = $urandom_range(0, 2) == 0; retire_dest = pick();
      end
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
